// File: rtl/tm_axis_packet_feeder.sv
// tm_axis_packet_feeder
//   AXI4-Stream slave front-end for the hard-coded TM inference top. Each
//   sample arrives as PACKETS_NUM beats. Every accepted beat is presented to
//   the inference top for exactly one cycle on x, with a one-hot strobe on
//   valid[] and its index on packet_counter. After the final beat the stream
//   is held off (tready low) until the top pulses finish.
//
// Ports
//   clk, rst         single clock; asynchronous active-high reset
//   s00_axis_*       stream slave (tdata/tvalid/tlast in, tready out)
//   finish           one-cycle pulse from the top: sample retired
//   x                packet data; tdata zero-extended or truncated to fit
//   valid            one-hot packet strobe, one cycle per accepted beat
//   packet_counter   index of the packet currently on x
//   last             pulses with the final packet when its beat carried tlast
//   s_axis_tready    copy of s00_axis_tready for the inference top
//   frame_err        sticky: tlast arrived on a non-final beat
//
// State table
//   ST_RECV | accepting beats of the current sample
//   ST_WAIT | full sample delivered; stream held off until finish

module tm_axis_packet_feeder #(
  parameter int PACKETS_NUM            = 13,
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              finish,
  output logic [C_M00_AXIS_TDATA_WIDTH:0]   x,
  output logic [PACKETS_NUM-1:0]            valid,
  output logic [C_M00_AXIS_TDATA_WIDTH:0]   packet_counter,
  output logic                              last,
  output logic                              s_axis_tready,
  output logic                              frame_err
);

  localparam int XW = C_M00_AXIS_TDATA_WIDTH + 1;
  localparam int CW = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PACKETS_NUM - 1);

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [XW-1:0]          x_d, pc_d;
  logic [PACKETS_NUM-1:0] valid_d;
  logic                   last_d, err_d, tready_d;
  logic                   accept;
  logic [XW-1:0]          tdata_ext;

  generate
    if (C_S00_AXIS_TDATA_WIDTH >= XW) begin : g_trunc
      assign tdata_ext = s00_axis_tdata[XW-1:0];
    end else begin : g_zext
      assign tdata_ext = {{(XW-C_S00_AXIS_TDATA_WIDTH){1'b0}}, s00_axis_tdata};
    end
  endgenerate

  assign accept        = s00_axis_tvalid & s00_axis_tready;
  assign s_axis_tready = s00_axis_tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x;
    pc_d    = packet_counter;
    valid_d = '0;
    last_d  = 1'b0;
    err_d   = frame_err;
    case (state_q)
      ST_RECV: begin
        if (accept) begin
          x_d     = tdata_ext;
          valid_d = PACKETS_NUM'(1) << cnt_q;
          pc_d    = XW'(cnt_q);
          if (cnt_q == CNT_LAST) begin
            last_d  = s00_axis_tlast;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else if (s00_axis_tlast) begin
            // Early tlast: drop the partial sample and resync to beat 0.
            // The final strobe never fires, so the top never starts on it.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (finish) state_d = ST_RECV;
      end
      default: state_d = ST_RECV;
    endcase
    // Registered from next state so tready has no combinational path from
    // tvalid, and stays low for the first cycle after reset release.
    tready_d = (state_d == ST_RECV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RECV;
      cnt_q           <= '0;
      x               <= '0;
      valid           <= '0;
      packet_counter  <= '0;
      last            <= 1'b0;
      frame_err       <= 1'b0;
      s00_axis_tready <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      x               <= x_d;
      valid           <= valid_d;
      packet_counter  <= pc_d;
      last            <= last_d;
      frame_err       <= err_d;
      s00_axis_tready <= tready_d;
    end
  end

endmodule
